// File: rtl/ads131_init_sequencer.sv
// ADS131A0x bring-up controller: hardware reset, READY poll, UNLOCK / WREG table /
// WAKEUP / LOCK with echo checks, then hands the SPI frame engine to the data path.
module ads131_init_sequencer #(
  parameter int RESET_LOW_CYCLES = 100,
  parameter int POR_WAIT_CYCLES  = 250000,
  parameter int NUM_REGS         = 4,
  parameter int READY_POLLS      = 16,
  parameter int TIMEOUT_CYCLES   = 50000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        init_start,
  output logic        spi_reset_n,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  input  logic        cmd_ready,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_word,
  output logic [3:0]  cfg_idx,
  input  logic [15:0] cfg_word,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  err_code,
  output logic [3:0]  state_dbg
);

  localparam int RW = $clog2(RESET_LOW_CYCLES) + 1;
  localparam int PW = $clog2(POR_WAIT_CYCLES) + 1;
  localparam int NW = $clog2(READY_POLLS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int MW = $clog2(MAX_RETRIES) + 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_LOW_CYCLES - 1);
  localparam logic [PW-1:0] POR_LAST  = PW'(POR_WAIT_CYCLES - 1);
  localparam logic [NW-1:0] POLL_LAST = NW'(READY_POLLS - 1);
  localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYCLES);
  localparam logic [MW-1:0] RETRY_MAX = MW'(MAX_RETRIES);
  localparam logic [3:0]    REG_LAST  = 4'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_HW_RST = 4'd1, S_POR_WAIT = 4'd2, S_POLL = 4'd3, S_UNLOCK = 4'd4,
    S_WREG = 4'd5, S_WAKEUP = 4'd6, S_LOCK = 4'd7, S_RUN = 4'd8, S_ERROR = 4'd9
  } state_t;

  state_t        state;
  logic [RW-1:0] rst_cnt;
  logic [PW-1:0] por_cnt;
  logic [NW-1:0] poll_cnt;
  logic [TW-1:0] tmo;
  logic [MW-1:0] retry;
  logic          pend;      // word accepted, response not yet seen
  logic          chk;       // second (NULL) transaction of a command step
  logic [15:0]   exp_word;

  logic          active;
  logic [15:0]   step_cmd, step_exp;
  logic [3:0]    step_code, abort_code;

  assign state_dbg = state;
  assign active    = state inside {S_POLL, S_UNLOCK, S_WREG, S_WAKEUP, S_LOCK};

  always_comb begin
    step_cmd  = 16'h0000;
    step_exp  = 16'h0000;
    step_code = 4'd0;
    case (state)
      S_UNLOCK: begin step_cmd = 16'h0655; step_exp = 16'h0655; step_code = 4'd3; end
      S_WREG: begin
        step_cmd  = {3'b010, cfg_word[12:0]};
        step_exp  = {3'b001, cfg_word[12:0]};
        step_code = 4'd4;
      end
      S_WAKEUP: begin step_cmd = 16'h0033; step_exp = 16'h0033; step_code = 4'd5; end
      S_LOCK:   begin step_cmd = 16'h0555; step_exp = 16'h0555; step_code = 4'd6; end
      default: ;
    endcase
  end

  // A response in the same cycle as the timeout takes priority over the timeout.
  always_comb begin
    abort_code = 4'd0;
    if (active) begin
      if (cmd_valid && !cmd_ready && tmo == TMO_LIM)
        abort_code = 4'd2;
      else if (!cmd_valid && pend && !rsp_valid && tmo == TMO_LIM)
        abort_code = 4'd2;
      else if (!cmd_valid && pend && rsp_valid) begin
        if (state == S_POLL) begin
          if (rsp_word[15:8] != 8'hFF && poll_cnt == POLL_LAST) abort_code = 4'd1;
        end else if (chk && rsp_word != exp_word && retry == RETRY_MAX) begin
          abort_code = step_code;
        end
      end
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state       <= S_IDLE;
      spi_reset_n <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_word    <= 16'h0000;
      cfg_idx     <= 4'd0;
      init_done   <= 1'b0;
      init_error  <= 1'b0;
      err_code    <= 4'd0;
      rst_cnt     <= '0;
      por_cnt     <= '0;
      poll_cnt    <= '0;
      tmo         <= '0;
      retry       <= '0;
      pend        <= 1'b0;
      chk         <= 1'b0;
      exp_word    <= 16'h0000;
    end else if (abort_code != 4'd0) begin
      state      <= S_ERROR;
      init_error <= 1'b1;
      err_code   <= abort_code;
      cmd_valid  <= 1'b0;
      pend       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_RUN, S_ERROR: if (init_start) begin
          state       <= S_HW_RST;
          spi_reset_n <= 1'b0;
          rst_cnt     <= '0;
          init_done   <= 1'b0;
          init_error  <= 1'b0;
          err_code    <= 4'd0;
          cfg_idx     <= 4'd0;
        end
        S_HW_RST: if (rst_cnt == RST_LAST) begin
          spi_reset_n <= 1'b1;
          por_cnt     <= '0;
          state       <= S_POR_WAIT;
        end else rst_cnt <= rst_cnt + 1'b1;
        S_POR_WAIT: if (por_cnt == POR_LAST) begin
          poll_cnt <= '0;
          pend     <= 1'b0;
          chk      <= 1'b0;
          retry    <= '0;
          state    <= S_POLL;
        end else por_cnt <= por_cnt + 1'b1;
        default: begin
          if (!cmd_valid && !pend) begin
            cmd_valid <= 1'b1;
            tmo       <= '0;
            if (state == S_POLL || chk) cmd_word <= 16'h0000;
            else begin
              cmd_word <= step_cmd;
              exp_word <= step_exp;
            end
          end else if (cmd_valid) begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              pend      <= 1'b1;
              tmo       <= '0;
            end else tmo <= tmo + 1'b1;
          end else if (rsp_valid) begin
            pend <= 1'b0;
            if (state == S_POLL) begin
              if (rsp_word[15:8] == 8'hFF) state <= S_UNLOCK;
              else poll_cnt <= poll_cnt + 1'b1;
            end else if (!chk) begin
              chk <= 1'b1;
            end else if (rsp_word == exp_word) begin
              chk   <= 1'b0;
              retry <= '0;
              case (state)
                S_UNLOCK: state <= S_WREG;
                S_WREG: if (cfg_idx == REG_LAST) begin
                  cfg_idx <= 4'd0;
                  state   <= S_WAKEUP;
                end else cfg_idx <= cfg_idx + 1'b1;
                S_WAKEUP: state <= S_LOCK;
                default: begin
                  state     <= S_RUN;
                  init_done <= 1'b1;
                end
              endcase
            end else begin
              chk   <= 1'b0;
              retry <= retry + 1'b1;
            end
          end else tmo <= tmo + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ads131_init_sequencer.sv
// Directed bench: a scripted SPI engine responder with a word scoreboard, plus
// checks of reset timing, polling, retries, timeout and restart behaviour.
module tb_ads131_init_sequencer;

  localparam int RLC  = 100;
  localparam int POR  = 300;
  localparam int TMO  = 500;
  localparam int NREG = 2;

  logic        system_clock = 1'b0;
  logic        reset, init_start;
  logic        spi_reset_n, cmd_valid, cmd_ready, rsp_valid;
  logic [15:0] cmd_word, rsp_word, cfg_word;
  logic [3:0]  cfg_idx, err_code, state_dbg;
  logic        init_done, init_error;

  logic [15:0] tbl [16];
  assign cfg_word = tbl[cfg_idx];

  ads131_init_sequencer #(
    .RESET_LOW_CYCLES(RLC), .POR_WAIT_CYCLES(POR), .NUM_REGS(NREG),
    .READY_POLLS(16), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(3)
  ) dut (
    .system_clock(system_clock), .reset(reset), .init_start(init_start),
    .spi_reset_n(spi_reset_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_word(rsp_word),
    .cfg_idx(cfg_idx), .cfg_word(cfg_word), .init_done(init_done),
    .init_error(init_error), .err_code(err_code), .state_dbg(state_dbg)
  );

  always #10 system_clock = ~system_clock;

  int          n_chk = 0, n_fail = 0;
  logic [15:0] exp_q [$];   // command words the DUT must issue, in order
  logic [15:0] rsp_q [$];   // forced responses, taking precedence over the echo model
  logic [15:0] echo_val, block_word;
  logic        ready_en;
  int          bad_wreg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: accepts words, answers two cycles later with the ADC's echo.
  initial begin
    logic [15:0] w, r;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_word = 16'h0000;
    forever begin
      @(negedge system_clock);
      rsp_valid = 1'b0;
      cmd_ready = ready_en && !(cmd_valid && cmd_word == block_word);
      if (cmd_valid && cmd_ready && !reset) begin
        w = cmd_word;
        chk("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("cmd_word", 32'(w), 32'(exp_q.pop_front()));
        if (w == 16'h0000) begin
          r = echo_val;
          if (bad_wreg > 0 && echo_val[15:13] == 3'b001) begin
            r = {echo_val[15:8], 8'h00};
            bad_wreg--;
          end
        end else begin
          r = 16'h0000;
          echo_val = (w[15:13] == 3'b010) ? {3'b001, w[12:0]} : w;
        end
        if (rsp_q.size() != 0) r = rsp_q.pop_front();
        @(negedge system_clock);
        cmd_ready = 1'b0;
        @(negedge system_clock);
        rsp_word = r; rsp_valid = 1'b1;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; init_start = 1'b0; ready_en = 1'b1;
    block_word = 16'hFFFF; bad_wreg = 0; echo_val = 16'hFF04;
    exp_q.delete(); rsp_q.delete();
    repeat (4) @(negedge system_clock);
    reset = 1'b0;
    @(negedge system_clock);
  endtask

  task automatic start();
    init_start = 1'b1;
    @(negedge system_clock);
    init_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!init_done && !init_error && n < 20000) begin
      @(negedge system_clock); n++;
    end
    chk(tag, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_word(input string tag, input logic [15:0] w);
    int n = 0;
    while (!(cmd_valid && cmd_word == w) && n < 5000) begin
      @(negedge system_clock); n++;
    end
    chk(tag, 32'(n < 5000), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) tbl[i] = 16'h0000;
    tbl[0] = 16'h0B0F; tbl[1] = 16'h1160;
    do_reset();

    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_spi_reset_n", 32'(spi_reset_n), 32'd1);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_word", 32'(cmd_word), 32'd0);
    chk("rst_flags", 32'({init_done, init_error, err_code, cfg_idx}), 32'd0);

    // Nominal run with reset pulse and power-on wait timing
    exp_q = {16'h0000, 16'h0655, 16'h0000, 16'h4B0F, 16'h0000, 16'h5160,
             16'h0000, 16'h0033, 16'h0000, 16'h0555, 16'h0000};
    start();
    chk("reset_n_fall", 32'(spi_reset_n), 32'd0);
    n = 0;
    while (spi_reset_n === 1'b0 && n < 1000) begin n++; @(negedge system_clock); end
    chk("reset_low_cycles", 32'(n), 32'(RLC));
    n = 0;
    while (!cmd_valid && n < 5000) begin @(negedge system_clock); n++; end
    chk("por_gap", 32'(n >= POR && n < 5000), 32'd1);
    wait_end("nominal_end");
    chk("nominal_done", 32'({init_done, init_error}), 32'b10);
    chk("nominal_err_code", 32'(err_code), 32'd0);
    chk("nominal_state", 32'(state_dbg), 32'd8);
    chk("nominal_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("nominal_all_words", 32'(exp_q.size()), 32'd0);

    // Restart from RUN
    start();
    chk("restart_state", 32'(state_dbg), 32'd1);
    chk("restart_done", 32'({init_done, spi_reset_n}), 32'd0);
    do_reset();

    // Two non-READY polls; init_start during POR_WAIT is ignored
    rsp_q = {16'h0000, 16'h0000};
    exp_q = {16'h0000, 16'h0000, 16'h0000, 16'h0655, 16'h0000, 16'h4B0F, 16'h0000,
             16'h5160, 16'h0000, 16'h0033, 16'h0000, 16'h0555, 16'h0000};
    start();
    n = 0;
    while (state_dbg != 4'd2 && n < 1000) begin @(negedge system_clock); n++; end
    start();
    chk("por_ignore_start", 32'({state_dbg, spi_reset_n}), 32'({4'd2, 1'b1}));
    wait_end("poll3_end");
    chk("poll3_done", 32'({init_done, err_code}), 32'({1'b1, 4'd0}));
    chk("poll3_all_words", 32'(exp_q.size()), 32'd0);
    do_reset();

    // READY never seen
    for (int i = 0; i < 16; i++) begin rsp_q.push_back(16'h0000); exp_q.push_back(16'h0000); end
    start();
    wait_end("poll_fail_end");
    chk("poll_fail_code", 32'({init_error, err_code, state_dbg}), 32'({1'b1, 4'd1, 4'd9}));
    chk("poll_fail_words", 32'(exp_q.size()), 32'd0);
    do_reset();

    // One WREG mismatch, then success
    bad_wreg = 1;
    exp_q = {16'h0000, 16'h0655, 16'h0000, 16'h4B0F, 16'h0000, 16'h4B0F, 16'h0000, 16'h5160,
             16'h0000, 16'h0033, 16'h0000, 16'h0555, 16'h0000};
    start();
    wait_end("retry_end");
    chk("retry_done", 32'({init_done, init_error, err_code}), 32'({2'b10, 4'd0}));
    chk("retry_words", 32'(exp_q.size()), 32'd0);
    do_reset();

    // Four WREG mismatches abort
    bad_wreg = 4;
    exp_q = {16'h0000, 16'h0655, 16'h0000};
    for (int i = 0; i < 4; i++) begin exp_q.push_back(16'h4B0F); exp_q.push_back(16'h0000); end
    start();
    wait_end("retry_fail_end");
    chk("retry_fail_code", 32'({init_error, err_code}), 32'({1'b1, 4'd4}));
    chk("retry_fail_words", 32'(exp_q.size()), 32'd0);
    do_reset();

    // UNLOCK never accepted
    block_word = 16'h0655;
    exp_q = {16'h0000};
    start();
    wait_word("tmo_unlock_seen", 16'h0655);
    n = 0;
    while (state_dbg != 4'd9 && n < 2000) begin @(negedge system_clock); n++; end
    chk("tmo_cycles", 32'(n >= TMO && n <= TMO + 2), 32'd1);
    chk("tmo_code", 32'({init_error, err_code, cmd_valid}), 32'({1'b1, 4'd2, 1'b0}));
    do_reset();

    // Reset while a WREG word is outstanding
    block_word = 16'h5160;
    exp_q = {16'h0000, 16'h0655, 16'h0000, 16'h4B0F, 16'h0000};
    start();
    wait_word("rst_mid_seen", 16'h5160);
    chk("rst_mid_cfg_idx", 32'(cfg_idx), 32'd1);
    reset = 1'b1;
    @(negedge system_clock);
    chk("rst_mid_state", 32'(state_dbg), 32'd0);
    chk("rst_mid_outputs", 32'({spi_reset_n, cmd_valid, cmd_word, cfg_idx}), 32'({1'b1, 1'b0, 16'h0, 4'd0}));
    chk("rst_mid_flags", 32'({init_done, init_error, err_code}), 32'd0);
    chk("rst_mid_words", 32'(exp_q.size()), 32'd0);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
